// File: rtl/tb_mem_pkg.sv
// Shared types and constants for the multi-channel streaming read memory model.
// Contents:
//   ch_state_e   - per-channel streaming state
//   LfsrWidth    - width of the optional stall-injection LFSR
//   LfsrTapMask  - Fibonacci feedback taps 16,14,13,11 (bit positions 15,13,12,10)
package tb_mem_pkg;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_STREAM,
        CH_DONE
    } ch_state_e;

    localparam int unsigned LfsrWidth   = 16;
    localparam logic [15:0] LfsrTapMask = 16'hB400;

endpackage

// File: rtl/tb_rd_stream_channel.sv
// One streaming read channel: replays the window [start,end] of a shared storage array
// onto a valid/ready port through a registered output stage.
// Optional feature: TB_MEM_STALL_INJECT_EN adds an LFSR that suppresses ~25% of loads.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              global enable; low blocks new loads
//   i_start           start pulse (honoured in IDLE/DONE only)
//   i_start_addr      window start, latched on start
//   i_end_addr        window end (inclusive), latched on start
//   i_loop_en         loop mode, latched on start
//   o_rd_idx          storage index to read this cycle
//   i_rd_data         word at o_rd_idx (with write-first bypass applied by the parent)
//   o_busy, o_done    state is STREAM / DONE
//   o_beat_cnt        accepted beats since last start
//   o_addr, o_data    presented word and its address
//   o_valid, i_ready  accelerator handshake
module tb_rd_stream_channel
    import tb_mem_pkg::*;
#(
    parameter int unsigned DataWidth = 512,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned MemIdxW   = 9,
    parameter int unsigned CntWidth  = 32,
    parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic [AddrWidth-1:0] i_start_addr,
    input  logic [AddrWidth-1:0] i_end_addr,
    input  logic                 i_loop_en,
    output logic [MemIdxW-1:0]   o_rd_idx,
    input  logic [DataWidth-1:0] i_rd_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CntWidth-1:0]  o_beat_cnt,
    output logic [AddrWidth-1:0] o_addr,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready
);

    localparam logic [MemIdxW-1:0]  IdxOne = MemIdxW'(1);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    ch_state_e              r_state;
    logic [MemIdxW-1:0]     r_ptr;
    logic [MemIdxW-1:0]     r_start_idx;
    logic [MemIdxW-1:0]     r_end_idx;
    logic                   r_loop;
    logic                   r_exhausted;
    logic                   r_valid;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_data;
    logic [CntWidth-1:0]    r_beat_cnt;

    logic                   w_stall;
    logic                   w_load;
    logic                   w_hs;

`ifdef TB_MEM_STALL_INJECT_EN
    logic [LfsrWidth-1:0]   r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= LfsrSeed;
        end else begin
            r_lfsr <= {r_lfsr[LfsrWidth-2:0], ^(r_lfsr & LfsrTapMask)};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign w_hs   = r_valid & i_ready;
    // A slot is free when nothing is presented or the presented word leaves this cycle.
    assign w_load = (r_state == CH_STREAM) & i_en & ~r_exhausted & (~r_valid | i_ready) & ~w_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= CH_IDLE;
            r_ptr       <= '0;
            r_start_idx <= '0;
            r_end_idx   <= '0;
            r_loop      <= 1'b0;
            r_exhausted <= 1'b0;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_beat_cnt  <= '0;
        end else begin
            unique case (r_state)
                CH_IDLE, CH_DONE: begin
                    if (i_start) begin
                        r_start_idx <= i_start_addr[MemIdxW-1:0];
                        r_end_idx   <= i_end_addr[MemIdxW-1:0];
                        r_loop      <= i_loop_en;
                        r_ptr       <= i_start_addr[MemIdxW-1:0];
                        r_beat_cnt  <= '0;
                        r_exhausted <= 1'b0;
                        r_state     <= CH_STREAM;
                    end
                end
                CH_STREAM: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + CntOne;
                    end
                    if (w_load) begin
                        r_data  <= i_rd_data;
                        r_addr  <= AddrWidth'(r_ptr);
                        r_valid <= 1'b1;
                        if (r_ptr == r_end_idx) begin
                            if (r_loop) begin
                                r_ptr <= r_start_idx;
                            end else begin
                                r_exhausted <= 1'b1;
                            end
                        end else begin
                            r_ptr <= r_ptr + IdxOne;
                        end
                    end else if (w_hs) begin
                        r_valid <= 1'b0;
                        // Final beat of a non-looping window has just been accepted.
                        if (r_exhausted) begin
                            r_state <= CH_DONE;
                        end
                    end
                end
                default: r_state <= CH_IDLE;
            endcase
        end
    end

    assign o_rd_idx   = r_ptr;
    assign o_busy     = (r_state == CH_STREAM);
    assign o_done     = (r_state == CH_DONE);
    assign o_beat_cnt = r_beat_cnt;
    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_valid    = r_valid;

endmodule

// File: rtl/tb_mc_rd_memory.sv
// Multi-channel streaming read memory model: one shared storage array with a backdoor
// write/read port and NumChannels independent streaming channels.
// Optional feature: TB_MEM_STALL_INJECT_EN enables per-channel LFSR load bubbles.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (storage is not reset)
//   en_i               global enable for channel loads
//   wr_addr_i/_data_i/_en_i   backdoor write
//   rd_addr_i/rd_data_o       backdoor combinational read
//   ch_start_addr_i, ch_end_addr_i, ch_loop_en_i, ch_start_i   per-channel control
//   ch_busy_o, ch_done_o, ch_beat_cnt_o                        per-channel status
//   acc_addr_o, acc_data_o, acc_valid_o, acc_ready_i           per-channel stream port
module tb_mc_rd_memory
    import tb_mem_pkg::*;
#(
    parameter int unsigned DataWidth   = 512,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned MemDepth    = 512,
    parameter int unsigned NumChannels = 2,
    parameter int unsigned CntWidth    = 32,
    parameter logic [15:0] StallSeed   = 16'hACE1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic [AddrWidth-1:0]             wr_addr_i,
    input  logic [DataWidth-1:0]             wr_data_i,
    input  logic                             wr_en_i,
    input  logic [AddrWidth-1:0]             rd_addr_i,
    output logic [DataWidth-1:0]             rd_data_o,
    input  logic [NumChannels*AddrWidth-1:0] ch_start_addr_i,
    input  logic [NumChannels*AddrWidth-1:0] ch_end_addr_i,
    input  logic [NumChannels-1:0]           ch_loop_en_i,
    input  logic [NumChannels-1:0]           ch_start_i,
    output logic [NumChannels-1:0]           ch_busy_o,
    output logic [NumChannels-1:0]           ch_done_o,
    output logic [NumChannels*CntWidth-1:0]  ch_beat_cnt_o,
    output logic [NumChannels*AddrWidth-1:0] acc_addr_o,
    output logic [NumChannels*DataWidth-1:0] acc_data_o,
    output logic [NumChannels-1:0]           acc_valid_o,
    input  logic [NumChannels-1:0]           acc_ready_i
);

    localparam int unsigned MemIdxW = $clog2(MemDepth);

    logic [DataWidth-1:0] r_mem [MemDepth];
    logic [MemIdxW-1:0]   w_wr_idx;

    assign w_wr_idx = wr_addr_i[MemIdxW-1:0];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[w_wr_idx] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_addr_i[MemIdxW-1:0]];

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
        logic [MemIdxW-1:0]   w_idx;
        logic [DataWidth-1:0] w_word;

        // Write-first: a same-cycle backdoor write to the loaded index wins.
        assign w_word = (wr_en_i && (w_wr_idx == w_idx)) ? wr_data_i : r_mem[w_idx];

        tb_rd_stream_channel #(
            .DataWidth (DataWidth),
            .AddrWidth (AddrWidth),
            .MemIdxW   (MemIdxW),
            .CntWidth  (CntWidth),
            .LfsrSeed  (StallSeed ^ 16'(gi))
        ) u_ch (
            .i_clk        (clk_i),
            .i_rst        (rst_i),
            .i_en         (en_i),
            .i_start      (ch_start_i[gi]),
            .i_start_addr (ch_start_addr_i[gi*AddrWidth +: AddrWidth]),
            .i_end_addr   (ch_end_addr_i[gi*AddrWidth +: AddrWidth]),
            .i_loop_en    (ch_loop_en_i[gi]),
            .o_rd_idx     (w_idx),
            .i_rd_data    (w_word),
            .o_busy       (ch_busy_o[gi]),
            .o_done       (ch_done_o[gi]),
            .o_beat_cnt   (ch_beat_cnt_o[gi*CntWidth +: CntWidth]),
            .o_addr       (acc_addr_o[gi*AddrWidth +: AddrWidth]),
            .o_data       (acc_data_o[gi*DataWidth +: DataWidth]),
            .o_valid      (acc_valid_o[gi]),
            .i_ready      (acc_ready_i[gi])
        );
    end

endmodule

// File: tb/tb_tb_mc_rd_memory.sv
// Directed bench for tb_mc_rd_memory (DataWidth=32, MemDepth=16, two channels).
module tb_tb_mc_rd_memory;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned MD = 16;
    localparam int unsigned NC = 2;
    localparam int unsigned CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic [NC*AW-1:0]  ch_start_addr;
    logic [NC*AW-1:0]  ch_end_addr;
    logic [NC-1:0]     ch_loop_en;
    logic [NC-1:0]     ch_start;
    logic [NC-1:0]     ch_busy;
    logic [NC-1:0]     ch_done;
    logic [NC*CW-1:0]  ch_beat_cnt;
    logic [NC*AW-1:0]  acc_addr;
    logic [NC*DW-1:0]  acc_data;
    logic [NC-1:0]     acc_valid;
    logic [NC-1:0]     acc_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model_mem [MD];
    logic [AW-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];

    always #5 clk = ~clk;

    tb_mc_rd_memory #(
        .DataWidth   (DW),
        .AddrWidth   (AW),
        .MemDepth    (MD),
        .NumChannels (NC),
        .CntWidth    (CW),
        .StallSeed   (16'hACE1)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .wr_en_i         (wr_en),
        .rd_addr_i       (rd_addr),
        .rd_data_o       (rd_data),
        .ch_start_addr_i (ch_start_addr),
        .ch_end_addr_i   (ch_end_addr),
        .ch_loop_en_i    (ch_loop_en),
        .ch_start_i      (ch_start),
        .ch_busy_o       (ch_busy),
        .ch_done_o       (ch_done),
        .ch_beat_cnt_o   (ch_beat_cnt),
        .acc_addr_o      (acc_addr),
        .acc_data_o      (acc_data),
        .acc_valid_o     (acc_valid),
        .acc_ready_i     (acc_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] addr_of(input int ch);
        return acc_addr[ch*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int ch);
        return acc_data[ch*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] beat_of(input int ch);
        return ch_beat_cnt[ch*CW +: CW];
    endfunction

    task automatic mem_write(input int a, input logic [DW-1:0] d);
        wr_addr = AW'(a);
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
        model_mem[a % MD] = d;
    endtask

    task automatic start_ch(input int ch, input int s, input int e, input logic lp);
        ch_start_addr[ch*AW +: AW] = AW'(s);
        ch_end_addr[ch*AW +: AW]   = AW'(e);
        ch_loop_en[ch]             = lp;
        ch_start[ch]               = 1'b1;
        step();
        ch_start[ch]               = 1'b0;
    endtask

    // Records every accepted beat; pat 0 = always ready, pat 1 = ready 1,0,0 repeating.
    task automatic collect(input int ch, input int n, input int pat, input int budget,
                           output int cycles);
        int            cyc;
        logic          rdy;
        logic          held;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        cyc  = 0;
        held = 1'b0;
        got_addr.delete();
        got_data.delete();
        while (got_addr.size() < n && cyc < budget) begin
            rdy = (pat == 0) || (cyc % 3 == 0);
            acc_ready[ch] = rdy;
            if (held) begin
                check_val("hold_valid", 64'(acc_valid[ch]), 64'd1);
                check_val("hold_addr", 64'(addr_of(ch)), 64'(h_addr));
                check_val("hold_data", 64'(data_of(ch)), 64'(h_data));
            end
            held = 1'b0;
            if (acc_valid[ch]) begin
                if (rdy) begin
                    got_addr.push_back(addr_of(ch));
                    got_data.push_back(data_of(ch));
                end else begin
                    held   = 1'b1;
                    h_addr = addr_of(ch);
                    h_data = data_of(ch);
                end
            end
            step();
            cyc++;
        end
        cycles = cyc;
        check_val("collect_count", 64'(got_addr.size()), 64'(n));
    endtask

    task automatic check_stream(input string tag, input int s, input int e, input int n);
        int a;
        a = s;
        for (int k = 0; k < n; k++) begin
            if (k < got_addr.size()) begin
                check_val({tag, "_addr"}, 64'(got_addr[k]), 64'(a));
                check_val({tag, "_data"}, 64'(got_data[k]), 64'(model_mem[a]));
            end
            a = (a == e) ? s : (a + 1) % MD;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst           = 1'b1;
        en            = 1'b1;
        wr_addr       = '0;
        wr_data       = '0;
        wr_en         = 1'b0;
        rd_addr       = '0;
        ch_start_addr = '0;
        ch_end_addr   = '0;
        ch_loop_en    = '0;
        ch_start      = '0;
        acc_ready     = '0;
        for (int i = 0; i < MD; i++) model_mem[i] = '0;
        step();
        step();
        for (int ch = 0; ch < NC; ch++) begin
            check_val("rst_valid", 64'(acc_valid[ch]), 64'd0);
            check_val("rst_busy", 64'(ch_busy[ch]), 64'd0);
            check_val("rst_done", 64'(ch_done[ch]), 64'd0);
            check_val("rst_beat", 64'(beat_of(ch)), 64'd0);
            check_val("rst_addr", 64'(addr_of(ch)), 64'd0);
            check_val("rst_data", 64'(data_of(ch)), 64'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < MD; i++) mem_write(i, DW'(i + 1));
        rd_addr = 32'd3;
        #1;
        check_val("bd_read", 64'(rd_data), 64'd4);
        rd_addr = 32'h15;  // high bits ignored: index 5
        #1;
        check_val("bd_read_hi", 64'(rd_data), 64'd6);

        // Single pass 2..5 -> data 3,4,5,6
        acc_ready[0] = 1'b1;
        start_ch(0, 2, 5, 1'b0);
`ifndef TB_MEM_STALL_INJECT_EN
        check_val("lat_latch_valid", 64'(acc_valid[0]), 64'd0);
        check_val("lat_busy", 64'(ch_busy[0]), 64'd1);
        step();
        check_val("lat_first_valid", 64'(acc_valid[0]), 64'd1);
        check_val("lat_first_addr", 64'(addr_of(0)), 64'd2);
        check_val("lat_first_data", 64'(data_of(0)), 64'd3);
`endif
        collect(0, 4, 0, 50, cyc);
`ifndef TB_MEM_STALL_INJECT_EN
        check_val("pass_cycles", 64'(cyc), 64'd4);
`endif
        check_stream("pass", 2, 5, 4);
        check_val("pass_done", 64'(ch_done[0]), 64'd1);
        check_val("pass_valid", 64'(acc_valid[0]), 64'd0);
        check_val("pass_busy", 64'(ch_busy[0]), 64'd0);
        check_val("pass_beat", 64'(beat_of(0)), 64'd4);

        // Backpressure
        start_ch(0, 2, 5, 1'b0);
        collect(0, 4, 1, 80, cyc);
        check_stream("bp", 2, 5, 4);
        check_val("bp_done", 64'(ch_done[0]), 64'd1);
        check_val("bp_beat", 64'(beat_of(0)), 64'd4);

        // Wrap 14,15,0,1
        acc_ready[0] = 1'b1;
        start_ch(0, 14, 1, 1'b0);
        collect(0, 4, 0, 50, cyc);
        check_stream("wrap", 14, 1, 4);
        check_val("wrap_done", 64'(ch_done[0]), 64'd1);

        // Loop on channel 1
        acc_ready[1] = 1'b1;
        start_ch(1, 0, 2, 1'b1);
        collect(1, 9, 0, 60, cyc);
        check_stream("loop", 0, 2, 9);
        check_val("loop_busy", 64'(ch_busy[1]), 64'd1);
        check_val("loop_beat", 64'(beat_of(1)), 64'd9);
        acc_ready[1] = 1'b0;

`ifndef TB_MEM_STALL_INJECT_EN
        // Write-first collision in the load cycle of index 3, then en_i freeze
        acc_ready[0] = 1'b1;
        start_ch(0, 0, 5, 1'b0);
        step();
        step();
        step();
        wr_addr = 32'd3;
        wr_data = 32'hA5A5_0003;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
        model_mem[3] = 32'hA5A5_0003;
        check_val("coll_addr", 64'(addr_of(0)), 64'd3);
        check_val("coll_data", 64'(data_of(0)), 64'hA5A5_0003);
        en           = 1'b0;
        acc_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("en_hold_valid", 64'(acc_valid[0]), 64'd1);
            check_val("en_hold_addr", 64'(addr_of(0)), 64'd3);
        end
        acc_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("en_no_load", 64'(acc_valid[0]), 64'd0);
        end
        check_val("en_beat", 64'(beat_of(0)), 64'd4);
        en = 1'b1;
        collect(0, 2, 0, 20, cyc);
        check_stream("en_tail", 4, 5, 2);
        check_val("en_done", 64'(ch_done[0]), 64'd1);
        check_val("en_final_beat", 64'(beat_of(0)), 64'd6);
`else
        // With bubbles a long looping pass must stay in order and complete
        acc_ready[0] = 1'b1;
        start_ch(0, 0, 15, 1'b1);
        collect(0, 64, 0, 1000, cyc);
        check_stream("stall", 0, 15, 64);
        check_val("stall_beat", 64'(beat_of(0)), 64'd64);
`endif

        // Reset mid-stream at beat 2
        acc_ready[0] = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_ch(0, 0, 7, 1'b0);
        collect(0, 2, 0, 20, cyc);
        check_val("mid_pre_valid", 64'(acc_valid[0]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid_valid", 64'(acc_valid[0]), 64'd0);
        check_val("mid_busy", 64'(ch_busy[0]), 64'd0);
        check_val("mid_beat", 64'(beat_of(0)), 64'd0);
        check_val("mid_ch1_valid", 64'(acc_valid[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
